// File: rtl/online_pkg.sv
// Shared types and helpers for the online-arithmetic output stage.
package online_pkg;

    typedef logic [2:0] digit_t;

    localparam int DIGIT_MAX = 2;
    localparam int DIGIT_MIN = -2;

    typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} conv_state_t;

    function automatic logic digit_is_legal(input digit_t d);
        int v;
        v = int'($signed(d));
        return (v >= DIGIT_MIN) && (v <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/online_to_parallel_converter_otf_step.sv
// One radix-4 on-the-fly conversion step: next Q and QM (= Q-1) for a legal digit.
module otf_step
    import online_pkg::*;
#(
    parameter int W = 43
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  digit_t       d,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    logic         neg;
    logic         pos;
    logic [W-1:0] q_src;
    logic [W-1:0] qm_src;

    assign neg = d[2];
    assign pos = !d[2] && (d[1:0] != 2'b00);

    // Appended digits (d mod 4, (d-1) mod 4) are always in 0..3, so the shift-in needs no carry.
    assign q_src   = neg ? qm : q;
    assign qm_src  = pos ? q  : qm;
    assign q_next  = {q_src[W-3:0],  d[1:0]};
    assign qm_next = {qm_src[W-3:0], d[1:0] - 2'd1};

endmodule

// File: rtl/online_to_parallel_converter.sv
// Drops the online-delay digits of an MSB-first radix-4 SD stream and converts the rest to two's complement.
module online_to_parallel_converter
    import online_pkg::*;
#(
    parameter  int N_DIGITS     = 21,
    parameter  int ONLINE_DELAY = 2,
    localparam int RES_W        = 2 * N_DIGITS + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  digit_t           d_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             digit_err,
    output logic             busy
);

    localparam int CNT_MAX = (ONLINE_DELAY > N_DIGITS) ? ONLINE_DELAY : N_DIGITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam conv_state_t      START_STATE = (ONLINE_DELAY > 0) ? SKIP : CONV;
    localparam logic [CNT_W-1:0] SKIP_LAST   = CNT_W'((ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(N_DIGITS - 1);

    conv_state_t      state, base_state, nxt_state;
    logic [CNT_W-1:0] cnt, base_cnt, nxt_cnt;
    logic [RES_W-1:0] q, base_q, nxt_q;
    logic [RES_W-1:0] qm, base_qm, nxt_qm;
    logic [RES_W-1:0] step_q, step_qm, nxt_result;
    logic             base_err, nxt_err;
    logic             legal, restart;
    digit_t           d_eff;

    otf_step #(.W(RES_W)) u_step (
        .q       (base_q),
        .qm      (base_qm),
        .d       (d_eff),
        .q_next  (step_q),
        .qm_next (step_qm)
    );

    always_comb begin
        legal   = digit_is_legal(d_in);
        d_eff   = legal ? d_in : digit_t'(0);
        restart = start && ((state != DONE) || out_ready);

        // A (re)start wipes the operation first; a digit accepted alongside it belongs to the new one.
        base_state = state;
        base_cnt   = cnt;
        base_q     = q;
        base_qm    = qm;
        base_err   = digit_err;
        if (restart) begin
            base_state = START_STATE;
            base_cnt   = '0;
            base_q     = '0;
            base_qm    = '1;
            base_err   = 1'b0;
        end

        nxt_state  = base_state;
        nxt_cnt    = base_cnt;
        nxt_q      = base_q;
        nxt_qm     = base_qm;
        nxt_err    = base_err;
        nxt_result = result;

        if (state == DONE) begin
            if (out_ready && !start) begin
                nxt_state = IDLE;
            end
        end else if (en) begin
            case (base_state)
                SKIP: begin
                    if (base_cnt == SKIP_LAST) begin
                        nxt_state = CONV;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = base_cnt + CNT_W'(1);
                    end
                end
                CONV: begin
                    nxt_q   = step_q;
                    nxt_qm  = step_qm;
                    nxt_err = base_err | !legal;
                    if (base_cnt == CONV_LAST) begin
                        nxt_state  = DONE;
                        nxt_cnt    = '0;
                        nxt_result = step_q;
                    end else begin
                        nxt_cnt = base_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= '0;
            qm        <= '1;
            result    <= '0;
            digit_err <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            q         <= nxt_q;
            qm        <= nxt_qm;
            result    <= nxt_result;
            digit_err <= nxt_err;
        end
    end

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
